// File: rtl/fpwbctrl_pkg.sv
// Shared FPU definitions: post-processor source classes and the pipe-tracker entry.
package fpwbctrl_pkg;

    localparam logic [1:0] CLS_CVT = 2'b00;
    localparam logic [1:0] CLS_DIV = 2'b01;
    localparam logic [1:0] CLS_FMA = 2'b10;

    typedef struct packed {
        logic       valid;
        logic [1:0] cls;
        logic [4:0] rd;
        logic       toint;
    } pipe_entry_t;

endpackage

// File: rtl/fppipetrack.sv
// FMALAT-stage shift register tracking fixed-latency ops; the last stage is the head.
module fppipetrack
    import fpwbctrl_pkg::*;
#(
    parameter int FMALAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  pipe_entry_t in_entry,
    output pipe_entry_t head
);

    pipe_entry_t stage_q [FMALAT];
    pipe_entry_t stage_d [FMALAT];

    always_comb begin
        stage_d[0] = in_entry;
        for (int i = 1; i < FMALAT; i++) begin
            stage_d[i] = stage_q[i-1];
        end
        if (flush) begin
            for (int i = 0; i < FMALAT; i++) begin
                stage_d[i].valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FMALAT; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign head = stage_q[FMALAT-1];

endmodule

// File: rtl/fpwbctrl.sv
// Writeback sequencer for the shared FPU post-processor: arbitrates the fixed-latency
// pipe against the single outstanding divide/sqrt and registers results and fflags.
module fpwbctrl
    import fpwbctrl_pkg::*;
#(
    parameter int FLEN   = 64,
    parameter int XLEN   = 64,
    parameter int FMALAT = 2
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   IssueValid,
    input  logic [1:0]                             IssueCls,
    input  logic [4:0]                             IssueRd,
    input  logic                                   IssueToInt,
    output logic                                   IssueStall,
    input  logic                                   FlushE,
    output logic                                   DivBusy,
    input  logic                                   DivDone,
    output logic                                   DivAck,
    output logic [1:0]                             PostProcSel,
    input  logic [FLEN-1:0]                        PostProcRes,
    input  logic [4:0]                             PostProcFlg,
    input  logic [XLEN-1:0]                        FCvtIntRes,
    output logic                                   WbValid,
    output logic [4:0]                             WbRd,
    output logic                                   WbToInt,
    output logic [((FLEN > XLEN) ? FLEN : XLEN)-1:0] WbData,
    input  logic                                   FFlagsWe,
    input  logic [4:0]                             FFlagsWd,
    output logic [4:0]                             FFlags
);

    localparam int DW = (FLEN > XLEN) ? FLEN : XLEN;

    pipe_entry_t   pipe_in, head;
    logic          head_v, div_ready, accept, sel_valid, sel_toint;
    logic [4:0]    sel_rd;

    logic          div_pend_q, div_pend_d;
    logic [4:0]    div_rd_q, div_rd_d;
    logic          div_toint_q, div_toint_d;
    logic          wb_valid_q, wb_valid_d;
    logic [4:0]    wb_rd_q, wb_rd_d;
    logic          wb_toint_q, wb_toint_d;
    logic [DW-1:0] wb_data_q, wb_data_d;
    logic [4:0]    fflags_q, fflags_d;

    fppipetrack #(.FMALAT(FMALAT)) u_track (
        .clk      (clk),
        .reset    (reset),
        .flush    (FlushE),
        .in_entry (pipe_in),
        .head     (head)
    );

    always_comb begin
        head_v    = head.valid;
        div_ready = div_pend_q & DivDone;
        // A done divider facing a busy head stalls issue, opening a bubble within FMALAT cycles.
        IssueStall = ~FlushE & ((IssueValid & (IssueCls == CLS_DIV) & div_pend_q) |
                                (div_ready & head_v));
        accept     = IssueValid & ~IssueStall & ~FlushE;

        pipe_in       = '0;
        pipe_in.valid = accept & ((IssueCls == CLS_CVT) | (IssueCls == CLS_FMA));
        pipe_in.cls   = IssueCls;
        pipe_in.rd    = IssueRd;
        pipe_in.toint = IssueToInt;

        sel_valid   = 1'b0;
        sel_rd      = div_rd_q;
        sel_toint   = div_toint_q;
        PostProcSel = CLS_FMA;
        DivAck      = 1'b0;
        if (head_v) begin
            sel_valid   = 1'b1;
            PostProcSel = head.cls;
            sel_rd      = head.rd;
            sel_toint   = head.toint;
        end else if (div_ready) begin
            sel_valid   = 1'b1;
            PostProcSel = CLS_DIV;
            DivAck      = 1'b1;
        end
        // Flush still drains a finished divider, but nothing it produces is kept.
        if (FlushE) begin
            sel_valid = 1'b0;
            DivAck    = div_ready;
        end

        div_pend_d  = div_pend_q & ~DivAck;
        div_rd_d    = div_rd_q;
        div_toint_d = div_toint_q;
        if (accept && IssueCls == CLS_DIV) begin
            div_pend_d  = 1'b1;
            div_rd_d    = IssueRd;
            div_toint_d = IssueToInt;
        end
        if (FlushE) begin
            div_pend_d = 1'b0;
        end

        wb_valid_d = sel_valid;
        wb_rd_d    = wb_rd_q;
        wb_toint_d = wb_toint_q;
        wb_data_d  = wb_data_q;
        if (sel_valid) begin
            wb_rd_d    = sel_rd;
            wb_toint_d = sel_toint;
            wb_data_d  = sel_toint ? DW'(FCvtIntRes) : DW'(PostProcRes);
        end

        fflags_d = (FFlagsWe ? FFlagsWd : fflags_q) | (sel_valid ? PostProcFlg : 5'b0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_pend_q  <= 1'b0;
            div_rd_q    <= '0;
            div_toint_q <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_toint_q  <= 1'b0;
            wb_data_q   <= '0;
            fflags_q    <= '0;
        end else begin
            div_pend_q  <= div_pend_d;
            div_rd_q    <= div_rd_d;
            div_toint_q <= div_toint_d;
            wb_valid_q  <= wb_valid_d;
            wb_rd_q     <= wb_rd_d;
            wb_toint_q  <= wb_toint_d;
            wb_data_q   <= wb_data_d;
            fflags_q    <= fflags_d;
        end
    end

    assign DivBusy = div_pend_q;
    assign WbValid = wb_valid_q;
    assign WbRd    = wb_rd_q;
    assign WbToInt = wb_toint_q;
    assign WbData  = wb_data_q;
    assign FFlags  = fflags_q;

endmodule

// File: tb/tb_fpwbctrl.sv
// Bench for fpwbctrl: directed vector table, hand-written corner sequences, then
// randomized traffic against a queue-based reference model.
module tb_fpwbctrl;

    localparam int FMALAT = 2;
    localparam logic [63:0] ONE = 64'h3FF0000000000000;

    logic        clk = 1'b0;
    logic        reset;
    logic        IssueValid, IssueToInt, IssueStall, FlushE, DivBusy, DivDone, DivAck;
    logic [1:0]  IssueCls, PostProcSel;
    logic [4:0]  IssueRd, PostProcFlg, WbRd, FFlagsWd, FFlags;
    logic [63:0] PostProcRes, FCvtIntRes, WbData;
    logic        WbValid, WbToInt, FFlagsWe;

    int checks = 0;
    int failures = 0;

    fpwbctrl #(.FLEN(64), .XLEN(64), .FMALAT(FMALAT)) dut (
        .clk(clk), .reset(reset),
        .IssueValid(IssueValid), .IssueCls(IssueCls), .IssueRd(IssueRd), .IssueToInt(IssueToInt),
        .IssueStall(IssueStall), .FlushE(FlushE), .DivBusy(DivBusy), .DivDone(DivDone),
        .DivAck(DivAck), .PostProcSel(PostProcSel), .PostProcRes(PostProcRes),
        .PostProcFlg(PostProcFlg), .FCvtIntRes(FCvtIntRes), .WbValid(WbValid), .WbRd(WbRd),
        .WbToInt(WbToInt), .WbData(WbData), .FFlagsWe(FFlagsWe), .FFlagsWd(FFlagsWd),
        .FFlags(FFlags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic iv; logic [1:0] cls; logic [4:0] rd; logic ti; logic fl; logic dn;
        logic [63:0] res; logic [63:0] cvt; logic [4:0] flg; logic we; logic [4:0] wd;
        logic e_stall; logic [1:0] e_sel; logic e_ack; logic e_wbv; logic [4:0] e_rd;
        logic e_ti; logic [63:0] e_data; logic [4:0] e_ffl; logic e_busy;
    } vec_t;

    typedef struct {
        logic [1:0] cls; logic [4:0] rd; logic toint; int due;
    } op_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle();
        IssueValid = 0; IssueCls = 0; IssueRd = 0; IssueToInt = 0; FlushE = 0; DivDone = 0;
        PostProcRes = 0; FCvtIntRes = 0; PostProcFlg = 0; FFlagsWe = 0; FFlagsWd = 0;
    endtask

    task automatic drive(input vec_t v);
        IssueValid = v.iv; IssueCls = v.cls; IssueRd = v.rd; IssueToInt = v.ti; FlushE = v.fl;
        DivDone = v.dn; PostProcRes = v.res; FCvtIntRes = v.cvt; PostProcFlg = v.flg;
        FFlagsWe = v.we; FFlagsWd = v.wd;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        reset = 1;
        repeat (2) @(negedge clk);
        reset = 0;
    endtask

    function automatic vec_t mk(logic iv, logic [1:0] cls, logic [4:0] rd, logic ti, logic fl,
                                logic dn, logic [63:0] res, logic [63:0] cvt, logic [4:0] flg,
                                logic we, logic [4:0] wd, logic es, logic [1:0] esel, logic ea,
                                logic ewbv, logic [4:0] erd, logic eti, logic [63:0] edata,
                                logic [4:0] effl, logic ebusy);
        vec_t v;
        v.iv = iv; v.cls = cls; v.rd = rd; v.ti = ti; v.fl = fl; v.dn = dn; v.res = res;
        v.cvt = cvt; v.flg = flg; v.we = we; v.wd = wd; v.e_stall = es; v.e_sel = esel;
        v.e_ack = ea; v.e_wbv = ewbv; v.e_rd = erd; v.e_ti = eti; v.e_data = edata;
        v.e_ffl = effl; v.e_busy = ebusy;
        return v;
    endfunction

    vec_t tbl [22];

    // reference model state
    op_t         mq[$];
    logic        m_pend, m_dti, m_wbv, m_wbti;
    logic [4:0]  m_drd, m_wbrd, m_ffl;
    logic [63:0] m_data;
    int          div_cnt;

    initial begin
        reset = 1;
        idle();

        tbl[0]  = mk(1,2,3,0,0,0, 0,0,0,0,0,           0,2,0, 0,0,0,0,0,0);
        tbl[1]  = mk(0,0,0,0,0,0, 0,0,0,0,0,           0,2,0, 0,0,0,0,0,0);
        tbl[2]  = mk(0,0,0,0,0,0, ONE,0,5'h01,0,0,     0,2,0, 0,0,0,0,0,0);
        tbl[3]  = mk(0,0,0,0,0,0, 0,0,0,0,0,           0,2,0, 1,3,0,ONE,5'h01,0);
        tbl[4]  = mk(1,0,9,1,0,0, 0,0,0,0,0,           0,2,0, 0,3,0,ONE,5'h01,0);
        tbl[5]  = mk(0,0,0,0,0,0, 0,0,0,0,0,           0,2,0, 0,3,0,ONE,5'h01,0);
        tbl[6]  = mk(0,0,0,0,0,0, 64'hDEAD,64'h1234,5'h10,1,0, 0,0,0, 0,3,0,ONE,5'h01,0);
        tbl[7]  = mk(0,0,0,0,0,0, 0,0,0,0,0,           0,2,0, 1,9,1,64'h1234,5'h10,0);
        tbl[8]  = mk(1,1,7,0,0,0, 0,0,0,0,0,           0,2,0, 0,9,1,64'h1234,5'h10,0);
        tbl[9]  = mk(1,1,8,0,0,0, 0,0,0,0,0,           1,2,0, 0,9,1,64'h1234,5'h10,1);
        tbl[10] = mk(1,1,8,0,0,1, 64'hAAAA,0,0,0,0,    1,1,1, 0,9,1,64'h1234,5'h10,1);
        tbl[11] = mk(1,1,8,0,0,0, 0,0,0,0,0,           0,2,0, 1,7,0,64'hAAAA,5'h10,0);
        tbl[12] = mk(0,0,0,0,0,0, 0,0,0,0,0,           0,2,0, 0,7,0,64'hAAAA,5'h10,1);
        tbl[13] = mk(0,0,0,0,0,1, 64'h55,0,5'h04,0,0,  0,1,1, 0,7,0,64'hAAAA,5'h10,1);
        tbl[14] = mk(0,0,0,0,0,0, 0,0,0,0,0,           0,2,0, 1,8,0,64'h55,5'h14,0);
        tbl[15] = mk(1,1,5,0,0,0, 0,0,0,0,0,           0,2,0, 0,8,0,64'h55,5'h14,0);
        tbl[16] = mk(1,2,4,0,0,0, 0,0,0,0,0,           0,2,0, 0,8,0,64'h55,5'h14,1);
        tbl[17] = mk(0,0,0,0,0,0, 0,0,0,0,0,           0,2,0, 0,8,0,64'h55,5'h14,1);
        tbl[18] = mk(1,2,30,0,1,1, 64'h77,0,5'h1F,0,0, 0,2,1, 0,8,0,64'h55,5'h14,1);
        tbl[19] = mk(0,0,0,0,0,0, 0,0,0,0,0,           0,2,0, 0,8,0,64'h55,5'h14,0);
        tbl[20] = mk(0,0,0,0,0,0, 0,0,0,0,0,           0,2,0, 0,8,0,64'h55,5'h14,0);
        tbl[21] = mk(0,0,0,0,0,0, 0,0,0,0,0,           0,2,0, 0,8,0,64'h55,5'h14,0);

        // reset state
        repeat (2) @(negedge clk);
        IssueValid = 1; IssueCls = 2'b01; DivDone = 1;
        #1;
        chk("rst_wbv", WbValid, 0);  chk("rst_wbrd", WbRd, 0);   chk("rst_wbti", WbToInt, 0);
        chk("rst_data", WbData, 0);  chk("rst_ffl", FFlags, 0);  chk("rst_busy", DivBusy, 0);
        chk("rst_sel", PostProcSel, 2'b10); chk("rst_ack", DivAck, 0); chk("rst_stall", IssueStall, 0);
        do_reset();

        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            chk($sformatf("v%0d_stall", i), IssueStall, tbl[i].e_stall);
            chk($sformatf("v%0d_sel", i), PostProcSel, tbl[i].e_sel);
            chk($sformatf("v%0d_ack", i), DivAck, tbl[i].e_ack);
            chk($sformatf("v%0d_wbv", i), WbValid, tbl[i].e_wbv);
            chk($sformatf("v%0d_wbrd", i), WbRd, tbl[i].e_rd);
            chk($sformatf("v%0d_wbti", i), WbToInt, tbl[i].e_ti);
            chk($sformatf("v%0d_data", i), WbData, tbl[i].e_data);
            chk($sformatf("v%0d_ffl", i), FFlags, tbl[i].e_ffl);
            chk($sformatf("v%0d_busy", i), DivBusy, tbl[i].e_busy);
        end

        // asynchronous reset mid-cycle clears registered outputs without a clock edge
        @(negedge clk);
        idle();
        #2 reset = 1;
        #1;
        chk("amid_wbrd", WbRd, 0); chk("amid_data", WbData, 0); chk("amid_ffl", FFlags, 0);
        chk("amid_busy", DivBusy, 0); chk("amid_wbv", WbValid, 0);
        @(negedge clk);
        reset = 0;

        // lone divide with long latency
        do_reset();
        @(negedge clk); idle();
        @(negedge clk); idle(); IssueValid = 1; IssueCls = 2'b01; IssueRd = 7;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk); idle(); #1;
            chk("ldiv_busy", DivBusy, 1); chk("ldiv_noack", DivAck, 0); chk("ldiv_nowb", WbValid, 0);
        end
        @(negedge clk); idle(); DivDone = 1; PostProcRes = 64'hC000000000000000; #1;
        chk("ldiv_ack", DivAck, 1); chk("ldiv_sel", PostProcSel, 2'b01);
        @(negedge clk); idle(); #1;
        chk("ldiv_wbv", WbValid, 1); chk("ldiv_wbrd", WbRd, 7);
        chk("ldiv_data", WbData, 64'hC000000000000000); chk("ldiv_busy0", DivBusy, 0);

        // collision: done divider against a back-to-back fma stream
        begin
            int next_rd, ack_at;
            logic stall_seen;
            logic [4:0] got[$];
            logic [4:0] exp_ord[7];
            exp_ord = '{5'd1, 5'd2, 5'd20, 5'd3, 5'd4, 5'd5, 5'd6};
            next_rd = 1; ack_at = -1; stall_seen = 0;
            do_reset();
            @(negedge clk); idle(); IssueValid = 1; IssueCls = 2'b01; IssueRd = 20;
            for (int k = 0; k < 16; k++) begin
                @(negedge clk); idle();
                if (next_rd <= 6) begin IssueValid = 1; IssueCls = 2'b10; IssueRd = 5'(next_rd); end
                DivDone = (k >= 2) && (ack_at < 0);
                PostProcRes = 64'(k);
                #1;
                if (WbValid) got.push_back(WbRd);
                if (DivAck && ack_at < 0) ack_at = k;
                if (IssueStall) stall_seen = 1;
                if (IssueValid && !IssueStall) next_rd++;
            end
            chk("coll_stall", stall_seen, 1);
            chk("coll_ack_cycle", 64'(ack_at), 64'd4);
            chk("coll_count", 64'(got.size()), 64'd7);
            for (int j = 0; j < 7; j++) begin
                chk($sformatf("coll_ord%0d", j), (j < got.size()) ? got[j] : 5'h1F, exp_ord[j]);
            end
        end

        // randomized traffic against the reference model
        do_reset();
        mq.delete();
        m_pend = 0; m_dti = 0; m_drd = 0; m_wbv = 0; m_wbti = 0; m_wbrd = 0; m_ffl = 0; m_data = 0;
        div_cnt = 0;
        for (int c = 0; c < 800; c++) begin
            logic head_v, dr, e_stall, e_ack, sel;
            logic [1:0] e_sel;
            @(negedge clk);
            IssueValid = ($urandom_range(0, 1) == 1);
            IssueCls = 2'($urandom_range(0, 3));
            IssueRd = 5'($urandom);
            IssueToInt = 1'($urandom);
            FlushE = ($urandom_range(0, 31) == 0);
            FFlagsWe = ($urandom_range(0, 15) == 0);
            FFlagsWd = 5'($urandom);
            PostProcFlg = 5'($urandom);
            PostProcRes = {$urandom, $urandom};
            FCvtIntRes = {$urandom, $urandom};
            DivDone = m_pend && (div_cnt == 0);
            #1;
            head_v = (mq.size() > 0) && (mq[0].due == c);
            dr = m_pend && DivDone;
            e_stall = !FlushE && ((IssueValid && IssueCls == 2'b01 && m_pend) || (dr && head_v));
            e_ack = FlushE ? dr : (!head_v && dr);
            e_sel = head_v ? mq[0].cls : (dr ? 2'b01 : 2'b10);
            chk("rnd_stall", IssueStall, e_stall); chk("rnd_sel", PostProcSel, e_sel);
            chk("rnd_ack", DivAck, e_ack);         chk("rnd_wbv", WbValid, m_wbv);
            chk("rnd_busy", DivBusy, m_pend);      chk("rnd_ffl", FFlags, m_ffl);
            if (m_wbv) begin
                chk("rnd_wbrd", WbRd, m_wbrd); chk("rnd_wbti", WbToInt, m_wbti);
                chk("rnd_data", WbData, m_data);
            end
            sel = !FlushE && (head_v || dr);
            m_ffl = (FFlagsWe ? FFlagsWd : m_ffl) | (sel ? PostProcFlg : 5'b0);
            m_wbv = sel;
            if (sel) begin
                m_wbrd = head_v ? mq[0].rd : m_drd;
                m_wbti = head_v ? mq[0].toint : m_dti;
                m_data = m_wbti ? FCvtIntRes : PostProcRes;
            end
            if (head_v) void'(mq.pop_front());
            if (e_ack) m_pend = 0;
            if (m_pend && div_cnt > 0) div_cnt--;
            if (FlushE) begin
                mq.delete();
                m_pend = 0;
            end else if (IssueValid && !e_stall) begin
                if (IssueCls == 2'b00 || IssueCls == 2'b10) begin
                    op_t o;
                    o.cls = IssueCls; o.rd = IssueRd; o.toint = IssueToInt; o.due = c + FMALAT;
                    mq.push_back(o);
                end else if (IssueCls == 2'b01) begin
                    m_pend = 1; m_drd = IssueRd; m_dti = IssueToInt;
                    div_cnt = $urandom_range(0, 5);
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
